// File: rtl/ifetch.sv
// Instruction fetch unit: reads an opcode byte and up to two operand bytes
// from 8-bit program memory and emits one pcinc pulse per accepted byte.
module ifetch #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_start,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pcinc,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic [7:0]        ir,
    output logic [15:0]       operand,
    output logic [1:0]        ir_len,
    output logic              ir_valid,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPC,
        S_OPL,
        S_OPH,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_ir;
    logic [15:0]       r_operand;
    logic [1:0]        r_len;
    logic              r_pcinc;
    logic              w_busy;
    logic              w_take;
    logic              w_start;
    logic [1:0]        w_len;

    function automatic logic [1:0] decode_len(input logic [7:0] opc);
        case (opc[7:6])
            2'b11:   decode_len = 2'd3;
            2'b10:   decode_len = 2'd2;
            default: decode_len = 2'd1;
        endcase
    endfunction

    assign w_busy  = (r_state == S_OPC) || (r_state == S_OPL) || (r_state == S_OPH);
    // A byte acked together with flush is dropped: no register update, no pcinc.
    assign w_take  = w_busy && mem_ack && !flush;
    assign w_start = ((r_state == S_IDLE) || (r_state == S_DONE)) && fetch_start && !flush;
    assign w_len   = decode_len(mem_rdata);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets a default before the case so no path infers a latch.
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (fetch_start) w_next = S_OPC;
                S_OPC:          if (mem_ack) w_next = (w_len == 2'd1) ? S_DONE : S_OPL;
                S_OPL:          if (mem_ack) w_next = (r_len == 2'd2) ? S_DONE : S_OPH;
                S_OPH:          if (mem_ack) w_next = S_DONE;
                default:        w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_ir      <= '0;
            r_operand <= '0;
            r_len     <= '0;
            r_pcinc   <= 1'b0;
        end else begin
            r_pcinc <= w_take;
            if (w_start) begin
                r_addr <= pc_addr;
            end else if (w_take) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_take) begin
                case (r_state)
                    S_OPC: begin
                        r_ir      <= mem_rdata;
                        r_len     <= w_len;
                        r_operand <= '0;
                    end
                    S_OPL:   r_operand[7:0]  <= mem_rdata;
                    S_OPH:   r_operand[15:8] <= mem_rdata;
                    default: ;
                endcase
            end
        end
    end

    assign pcinc    = r_pcinc;
    assign mem_rd   = w_busy;
    assign mem_addr = r_addr;
    assign ir       = r_ir;
    assign operand  = r_operand;
    assign ir_len   = r_len;
    assign ir_valid = (r_state == S_DONE);
    assign busy     = w_busy;

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch with a behavioural wait-state memory.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_start = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] pc_addr = 16'h0000;
    logic        pcinc;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic [7:0]  ir;
    logic [15:0] operand;
    logic [1:0]  ir_len;
    logic        ir_valid;
    logic        busy;

    int total = 0;
    int bad = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] addr_q[$];
    int          pcinc_cnt = 0;
    int          stab_err = 0;
    int          wait_cycles = 0;
    int          wcnt = 0;
    logic [15:0] hold_addr = 16'h0000;

    ifetch #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .fetch_start(fetch_start), .flush(flush),
        .pc_addr(pc_addr), .pcinc(pcinc), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir(ir), .operand(operand),
        .ir_len(ir_len), .ir_valid(ir_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory responder: acks after wait_cycles idle cycles per byte, logs
    // acked addresses, counts pcinc pulses and checks address stability.
    always @(negedge clk) begin
        if (pcinc) pcinc_cnt++;
        if (rst || !mem_rd) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else if (wcnt >= wait_cycles) begin
            if (wait_cycles > 0 && mem_addr !== hold_addr) stab_err++;
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            addr_q.push_back(mem_addr);
            wcnt      = 0;
        end else begin
            if (wcnt == 0) hold_addr = mem_addr;
            else if (mem_addr !== hold_addr) stab_err++;
            mem_ack = 1'b0;
            wcnt++;
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if ({pcinc, mem_rd, mem_addr, ir, operand, ir_len, ir_valid, busy} !== '0) begin
            bad++;
            $display("FAIL %s: outs pcinc=%b rd=%b addr=%h ir=%h op=%h len=%0d v=%b busy=%b, required all 0",
                     name, pcinc, mem_rd, mem_addr, ir, operand, ir_len, ir_valid, busy);
        end
    endtask

    task automatic do_fetch(input string name, input logic [15:0] pc, input int waits,
                            input logic [7:0] e_ir, input logic [15:0] e_op,
                            input logic [1:0] e_len, input int e_cyc, input bit poke);
        int cyc, p0, a0, s0;
        logic [15:0] e_addr;
        wait_cycles = waits;
        p0 = pcinc_cnt;
        a0 = addr_q.size();
        s0 = stab_err;
        pc_addr = pc;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        cyc = 1;
        total++;
        if (ir_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== pc) begin
            bad++;
            $display("FAIL %s start: v=%b rd=%b addr=%h, required v=0 rd=1 addr=%h",
                     name, ir_valid, mem_rd, mem_addr, pc);
        end
        while (!ir_valid && cyc < 100) begin
            if (poke && cyc == 2) begin
                fetch_start = 1'b1;
                pc_addr     = 16'hDEAD;
            end else begin
                fetch_start = 1'b0;
            end
            tick();
            cyc++;
        end
        fetch_start = 1'b0;
        total++;
        if (cyc != e_cyc) begin
            bad++;
            $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc, e_cyc);
        end
        total++;
        if (ir !== e_ir || operand !== e_op || ir_len !== e_len) begin
            bad++;
            $display("FAIL %s result: ir=%h op=%h len=%0d, required ir=%h op=%h len=%0d",
                     name, ir, operand, ir_len, e_ir, e_op, e_len);
        end
        total++;
        if (pcinc_cnt - p0 != int'(e_len) || mem_rd !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s pcinc/idle: pulses=%0d rd=%b busy=%b, required pulses=%0d rd=0 busy=0",
                     name, pcinc_cnt - p0, mem_rd, busy, e_len);
        end
        total++;
        if (addr_q.size() - a0 != int'(e_len)) begin
            bad++;
            $display("FAIL %s addr count: got %0d, required %0d", name, addr_q.size() - a0, e_len);
        end else begin
            for (int i = 0; i < int'(e_len); i++) begin
                e_addr = pc + 16'(i);
                if (addr_q[a0 + i] !== e_addr) begin
                    bad++;
                    $display("FAIL %s addr[%0d]: got %h, required %h", name, i, addr_q[a0 + i], e_addr);
                end
            end
        end
        total++;
        if (stab_err != s0) begin
            bad++;
            $display("FAIL %s addr stable: %0d changes during wait, required 0", name, stab_err - s0);
        end
    endtask

    task automatic test_reset;
        int p0;
        #1;
        check_all_zero("reset_held");
        repeat (2) tick();
        rst = 1'b0;
        p0 = pcinc_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all_zero("reset_idle");
        end
        total++;
        if (pcinc_cnt != p0) begin
            bad++;
            $display("FAIL reset_pcinc: got %0d pulses, required 0", pcinc_cnt - p0);
        end
    endtask

    task automatic test_three_byte;
        mem[16'h0100] = 8'hC3; mem[16'h0101] = 8'h34; mem[16'h0102] = 8'h12;
        do_fetch("three_byte", 16'h0100, 0, 8'hC3, 16'h1234, 2'd3, 4, 1'b0);
    endtask

    task automatic test_wait_states;
        mem[16'h0020] = 8'h85; mem[16'h0021] = 8'h7F;
        // Zero-wait 2-byte is 3 cycles; two waits on each of two bytes add 4.
        do_fetch("wait_states", 16'h0020, 2, 8'h85, 16'h007F, 2'd2, 7, 1'b0);
    endtask

    task automatic test_wrap;
        mem[16'hFFFF] = 8'hC1; mem[16'h0000] = 8'hEF; mem[16'h0001] = 8'hBE;
        do_fetch("wrap", 16'hFFFF, 0, 8'hC1, 16'hBEEF, 2'd3, 4, 1'b0);
    endtask

    task automatic test_ignored_start;
        mem[16'h0500] = 8'hD0; mem[16'h0501] = 8'h78; mem[16'h0502] = 8'h56;
        do_fetch("ignored_start", 16'h0500, 1, 8'hD0, 16'h5678, 2'd3, 7, 1'b1);
    endtask

    task automatic test_back_to_back;
        mem[16'h0600] = 8'h3A; mem[16'h0601] = 8'h9B; mem[16'h0602] = 8'h44;
        do_fetch("b2b_first", 16'h0600, 0, 8'h3A, 16'h0000, 2'd1, 2, 1'b0);
        repeat (3) tick();
        total++;
        if (ir_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_hold: ir_valid=%b, required 1", ir_valid);
        end
        do_fetch("b2b_second", 16'h0601, 0, 8'h9B, 16'h0044, 2'd2, 3, 1'b0);
    endtask

    task automatic test_flush;
        int p0;
        mem[16'h0200] = 8'hC3; mem[16'h0201] = 8'hAA; mem[16'h0202] = 8'hBB;
        mem[16'h0300] = 8'h05;
        wait_cycles = 0;
        p0 = pcinc_cnt;
        pc_addr = 16'h0200;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        flush = 1'b1;
        fetch_start = 1'b1;
        tick();
        flush = 1'b0;
        fetch_start = 1'b0;
        total++;
        if (mem_rd !== 1'b0 || busy !== 1'b0 || ir_valid !== 1'b0 || pcinc !== 1'b0) begin
            bad++;
            $display("FAIL flush_next: rd=%b busy=%b v=%b pcinc=%b, required all 0",
                     mem_rd, busy, ir_valid, pcinc);
        end
        repeat (2) tick();
        total++;
        if (pcinc_cnt - p0 != 1 || mem_rd !== 1'b0) begin
            bad++;
            $display("FAIL flush_pcinc: pulses=%0d rd=%b, required pulses=1 rd=0", pcinc_cnt - p0, mem_rd);
        end
        do_fetch("after_flush", 16'h0300, 0, 8'h05, 16'h0000, 2'd1, 2, 1'b0);
    endtask

    task automatic test_reset_mid;
        int p0, guard;
        mem[16'h0400] = 8'hC0; mem[16'h0401] = 8'h11; mem[16'h0402] = 8'h22;
        wait_cycles = 3;
        pc_addr = 16'h0400;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        guard = 0;
        while (!(mem_rd === 1'b1 && mem_addr === 16'h0402) && guard < 60) begin
            tick();
            guard++;
        end
        total++;
        if (guard >= 60) begin
            bad++;
            $display("FAIL reset_mid_reach: OPH address 0402 not seen, last addr=%h", mem_addr);
        end
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid_async");
        p0 = pcinc_cnt;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        total++;
        if (pcinc_cnt != p0 || mem_rd !== 1'b0 || ir_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_after: pulses=%0d rd=%b v=%b, required 0 0 0",
                     pcinc_cnt - p0, mem_rd, ir_valid);
        end
    endtask

    initial begin
        test_reset();
        test_three_byte();
        test_wait_states();
        test_wrap();
        test_ignored_start();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
